// File: rtl/rand_pkg.sv
// Shared types and constants for the pseudo-random operand source.
package rand_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  localparam logic [LFSR_W-1:0] LFSR_NONZERO = 10'h001;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PENDING
  } state_e;

  // Fibonacci step for x^10 + x^7 + 1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR with a synchronous load that can never lock up at zero.
module lfsr10
  import rand_pkg::*;
(
  input  logic              clk,
  input  logic              Reset,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '0) ? LFSR_NONZERO : load_val;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      q_q <= LFSR_NONZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rand_source.sv
// Periodic sampler: captures the free-running LFSR into A every max(period,1) cycles,
// deferring a due sample while freeze is high.
module rand_source
  import rand_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic              freeze,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [PER_W-1:0]  period,
  output logic [LFSR_W-1:0] A,
  output logic              A_valid
);

  state_e            state_q, state_d;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] a_q, a_d;
  logic              a_valid_q, a_valid_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [PER_W-1:0]  reload_val;
  logic              capture;

  lfsr10 u_lfsr (
    .clk      (clk),
    .Reset    (Reset),
    .step     (enable),
    .load     (seed_load),
    .load_val (seed),
    .q        (lfsr_q)
  );

  // A period of 0 behaves as 1, so the terminal count is max(period,1)-1.
  assign reload_val = (period == '0) ? '0 : period - PER_W'(1);

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COUNT;
          cnt_d   = reload_val;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - PER_W'(1);
        end else if (!freeze) begin
          capture = 1'b1;
          cnt_d   = reload_val;
        end else begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!freeze) begin
          capture = 1'b1;
          cnt_d   = reload_val;
          state_d = COUNT;
        end
      end
      default: state_d = IDLE;
    endcase

    // A seed load restarts the sample interval regardless of FSM activity.
    if (seed_load) begin
      cnt_d = reload_val;
    end

    a_d       = capture ? lfsr_q : a_q;
    a_valid_d = capture;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign A       = a_q;
  assign A_valid = a_valid_q;

endmodule

// File: tb/tb_rand_source.sv
// Scoreboard bench for rand_source: the driver queues each expected sample
// (value and pulse cycle); a negedge monitor pops and compares on every A_valid.
module tb_rand_source;

  localparam int PER_W = 16;

  logic             clk = 1'b0;
  logic             Reset;
  logic             enable;
  logic             freeze;
  logic             seed_load;
  logic [9:0]       seed;
  logic [PER_W-1:0] period;
  logic [9:0]       A;
  logic             A_valid;

  rand_source #(.PER_W(PER_W)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .enable    (enable),
    .freeze    (freeze),
    .seed_load (seed_load),
    .seed      (seed),
    .period    (period),
    .A         (A),
    .A_valid   (A_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] val;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [9:0] seen[$];
  bit         collect = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] lfsr_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] ref_next(input logic [9:0] v);
    logic [9:0] r;
    r = {v[8:0], v[9] ^ v[6]};
    return r;
  endfunction

  // Advance one edge; if cap is set, this edge is a capture edge and the
  // pre-edge LFSR value is the expected sample.
  task automatic step_edge(input bit cap);
    exp_t e;
    if (cap) begin
      e.val = lfsr_m;
      e.cyc = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!Reset)         lfsr_m = 10'h001;
    else if (seed_load) lfsr_m = (seed == 10'h000) ? 10'h001 : seed;
    else if (enable)    lfsr_m = ref_next(lfsr_m);
    #1;
  endtask

  always @(negedge clk) begin
    if (A_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: A_valid=1 with A=%0h, expected no pulse (cycle %0d)", A, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sample_value", 32'(A), 32'(e.val));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        if (collect) seen.push_back(A);
      end
    end
  end

  initial begin
    logic [9:0] a_hold;
    int         dups;
    int         zeros;
    bit         used [0:1023];

    Reset = 1'b0; enable = 1'b0; freeze = 1'b0; seed_load = 1'b0;
    seed = '0; period = '0; lfsr_m = 10'h001;

    // Reset state and 100 idle cycles.
    #3;
    check("reset_A", 32'(A), 32'h0);
    check("reset_A_valid", 32'(A_valid), 32'h0);
    step_edge(0); step_edge(0);
    Reset = 1'b1;
    repeat (100) step_edge(0);
    check("idle_A", 32'(A), 32'h0);

    // Full sequence from seed 1 at period 1.
    seed = 10'h001; seed_load = 1'b1;
    step_edge(0);
    seed_load = 1'b0; period = 16'd1; enable = 1'b1; collect = 1'b1;
    step_edge(0);
    repeat (1024) step_edge(1);
    enable = 1'b0;
    step_edge(0);
    collect = 1'b0;
    check("seq_len", 32'(seen.size()), 32'd1024);
    dups = 0; zeros = 0;
    foreach (used[i]) used[i] = 1'b0;
    for (int i = 0; i < 1023 && i < seen.size(); i++) begin
      if (seen[i] == 10'h000) zeros++;
      else if (used[seen[i]]) dups++;
      used[seen[i]] = 1'b1;
    end
    check("seq_distinct", 32'(dups), 32'd0);
    check("seq_nonzero", 32'(zeros), 32'd0);
    if (seen.size() >= 1024) check("seq_wrap", 32'(seen[1023]), 32'(seen[0]));

    // Seed 0 is replaced by 1; period 0 behaves as period 1.
    seed = 10'h000; seed_load = 1'b1;
    step_edge(0);
    seed_load = 1'b0; period = 16'd0; enable = 1'b1;
    step_edge(0);
    repeat (30) step_edge(1);
    enable = 1'b0;
    step_edge(0);

    // Period 4 with freeze over a terminal count, then a period change mid-count.
    period = 16'd4; enable = 1'b1;
    step_edge(0);
    for (int k = 1; k <= 9; k++) step_edge(k == 4 || k == 8);
    a_hold = A;
    freeze = 1'b1;
    for (int k = 10; k <= 15; k++) begin
      step_edge(0);
      check("frozen_A_stable", 32'(A), 32'(a_hold));
    end
    freeze = 1'b0;
    step_edge(1);
    period = 16'd2;
    repeat (3) step_edge(0);
    step_edge(1);
    step_edge(0);
    step_edge(1);
    enable = 1'b0;
    step_edge(0);

    // Seed load mid-count restarts the interval; at a capture edge the capture sees the old LFSR.
    period = 16'd3; enable = 1'b1;
    step_edge(0);
    seed = 10'h155; seed_load = 1'b1;
    step_edge(0);
    seed_load = 1'b0;
    step_edge(0); step_edge(0);
    step_edge(1);
    step_edge(0); step_edge(0);
    seed = 10'h0F0; seed_load = 1'b1;
    step_edge(1);
    seed_load = 1'b0;
    step_edge(0); step_edge(0);
    step_edge(1);
    enable = 1'b0;
    step_edge(0);

    // Asynchronous reset mid-COUNT with A = 2A5, then restart from IDLE at period 3.
    period = 16'd1; seed = 10'h2A5; seed_load = 1'b1; enable = 1'b1;
    step_edge(0);
    seed_load = 1'b0; period = 16'd3;
    step_edge(0);
    check("pre_reset_A", 32'(A), 32'h2A5);
    check("pre_reset_A_valid", 32'(A_valid), 32'h1);
    Reset = 1'b0;
    #2;
    check("async_reset_A", 32'(A), 32'h0);
    check("async_reset_A_valid", 32'(A_valid), 32'h0);
    lfsr_m = 10'h001;
    step_edge(0); step_edge(0);
    Reset = 1'b1;
    step_edge(0);
    step_edge(0); step_edge(0);
    step_edge(1);
    step_edge(0); step_edge(0);
    step_edge(1);
    enable = 1'b0;
    step_edge(0); step_edge(0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rand_source.md
RAND_SOURCE -- requirements
Module: rand_source

Interface
REQ-001 Parameter PER_W, default 16: width of the sample-period input.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 enable  input  1  run request; 1 = produce samples.
REQ-005 freeze  input  1  1 = hold A stable and defer any due sample.
REQ-006 seed_load  input  1  single-cycle request to load seed into the LFSR.
REQ-007 seed  input  10  LFSR seed value.
REQ-008 period  input  PER_W  cycles between samples; 0 is treated as 1.
REQ-009 A  output  10  held pseudo-random operand for the downstream magnitude comparator.
REQ-010 A_valid  output  1  one-cycle pulse in the cycle after A is updated.

Function
REQ-011 The LFSR SHALL be 10-bit Fibonacci, x^10+x^7+1: next = {q[8:0], q[9]^q[6]}; period 1023; never zero.
REQ-012 The LFSR SHALL step every clock while enable=1, independent of freeze and of FSM state, and hold while enable=0.
REQ-013 seed_load=1 SHALL set the LFSR to seed (seed=0 substituted by 10'h001) on that edge, override stepping, and reload the counter.
REQ-014 The FSM SHALL have states IDLE, COUNT, PENDING.
REQ-015 IDLE: on enable=1, go to COUNT with cnt <= max(period,1)-1.
REQ-016 COUNT: if cnt!=0, decrement; if cnt==0 and freeze=0, capture A <= current LFSR value, assert A_valid next cycle, reload cnt; if cnt==0 and freeze=1, go to PENDING.
REQ-017 PENDING: hold A; on the first cycle with freeze=0, capture A, pulse A_valid, go to COUNT with reload.
REQ-018 enable=0 in any state SHALL go to IDLE on the next edge, with no capture and no pulse; A SHALL keep its last value.
REQ-019 First A_valid after enable rises (freeze=0, enable held) SHALL come exactly max(period,1) cycles after the edge that enters COUNT; following pulses SHALL come every max(period,1) cycles.
REQ-020 A change to period SHALL take effect only at the next reload.
REQ-021 If seed_load and a capture coincide, the capture SHALL use the pre-load LFSR value; the counter reload from seed_load SHALL take precedence.
REQ-022 A SHALL change only on a capture edge; A_valid SHALL never be high for two consecutive cycles unless period<=1.

Reset
REQ-023 Reset=0 SHALL immediately force: LFSR=10'h001, A=10'h000, A_valid=0, cnt=0, state=IDLE.
REQ-024 Reset in mid-COUNT or mid-PENDING SHALL discard the deferred sample; after release the block SHALL restart from IDLE.

Structure
REQ-025 Package rand_pkg SHALL hold the state enum (IDLE, COUNT, PENDING), LFSR width 10, tap positions (9, 6), and the non-zero substitute 10'h001.
REQ-026 The LFSR SHALL be a sub-module lfsr10 (clk, Reset, step, load, load_val, q); the FSM, counter, and A register SHALL stay in rand_source.

Verification
REQ-027 Reset released, enable=0 for 100 cycles -> A=10'h000, A_valid never 1.
REQ-028 seed_load with seed=10'h001, then enable=1 with period=1 -> A_valid every cycle; 1023 consecutive A values are all distinct and non-zero, and value 1024 equals value 1.
REQ-029 seed_load with seed=10'h000 -> LFSR=10'h001 on the next cycle; the sequence matches REQ-028.
REQ-030 period=4, freeze=1 from two cycles before a terminal count for 6 cycles -> no pulse while frozen, A stable; pulse in the cycle after freeze falls, next pulse 4 cycles later.
REQ-031 period=0 -> behaves identically to period=1.
REQ-032 Reset=0 asserted between clock edges in COUNT with A=10'h2A5 -> A=0 and A_valid=0 immediately; after release, with enable=1 and period=3, first pulse 3 cycles after entering COUNT.
